// File: rtl/vga_sync_gen.sv
// VGA timing generator: column/row counters with registered active-area flags,
// porch-adjusted pin syncs and line/frame start pulses, all decoded from the next count.
module vga_sync_gen #(
    parameter int TOTAL_COLS      = 800,
    parameter int TOTAL_ROWS      = 525,
    parameter int ACTIVE_COLS     = 640,
    parameter int ACTIVE_ROWS     = 480,
    parameter int H_FRONT_PORCH   = 16,
    parameter int H_SYNC_WIDTH    = 96,
    parameter int V_FRONT_PORCH   = 10,
    parameter int V_SYNC_WIDTH    = 2,
    parameter int SYNC_ACTIVE_LOW = 1
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_enable,
    output logic       o_hsync,
    output logic       o_vsync,
    output logic       o_vga_hs,
    output logic       o_vga_vs,
    output logic       o_active,
    output logic [9:0] o_col_count,
    output logic [9:0] o_row_count,
    output logic       o_line_start,
    output logic       o_frame_start
);

    // Thresholds are 11 bits so a pulse ending exactly at TOTAL = 1024 still compares correctly.
    localparam logic [9:0]  COL_LAST  = 10'(TOTAL_COLS - 1);
    localparam logic [9:0]  ROW_LAST  = 10'(TOTAL_ROWS - 1);
    localparam logic [10:0] H_ACT     = 11'(ACTIVE_COLS);
    localparam logic [10:0] V_ACT     = 11'(ACTIVE_ROWS);
    localparam logic [10:0] H_PULSE_S = 11'(ACTIVE_COLS + H_FRONT_PORCH);
    localparam logic [10:0] H_PULSE_E = 11'(ACTIVE_COLS + H_FRONT_PORCH + H_SYNC_WIDTH);
    localparam logic [10:0] V_PULSE_S = 11'(ACTIVE_ROWS + V_FRONT_PORCH);
    localparam logic [10:0] V_PULSE_E = 11'(ACTIVE_ROWS + V_FRONT_PORCH + V_SYNC_WIDTH);
    localparam logic        PIN_IDLE  = (SYNC_ACTIVE_LOW != 0);

    localparam bit PARAMS_OK =
        (ACTIVE_COLS + H_FRONT_PORCH + H_SYNC_WIDTH <= TOTAL_COLS) &&
        (ACTIVE_ROWS + V_FRONT_PORCH + V_SYNC_WIDTH <= TOTAL_ROWS) &&
        (TOTAL_COLS <= 1024) && (TOTAL_ROWS <= 1024) &&
        (TOTAL_COLS >= 2) && (TOTAL_ROWS >= 1);

    logic [9:0] col_q, col_d, row_q, row_d;
    logic [9:0] col_nx, row_nx;
    logic       hsync_q, hsync_d, vsync_q, vsync_d, active_q, active_d;
    logic       vga_hs_q, vga_hs_d, vga_vs_q, vga_vs_d;
    logic       line_start_q, line_start_d, frame_start_q, frame_start_d;
    logic       h_pulse, v_pulse;

    always_comb begin
        col_nx = col_q;
        row_nx = row_q;
        if (col_q == COL_LAST) begin
            col_nx = '0;
            row_nx = (row_q == ROW_LAST) ? '0 : row_q + 10'd1;
        end else begin
            col_nx = col_q + 10'd1;
        end

        h_pulse = ({1'b0, col_nx} >= H_PULSE_S) && ({1'b0, col_nx} < H_PULSE_E);
        v_pulse = ({1'b0, row_nx} >= V_PULSE_S) && ({1'b0, row_nx} < V_PULSE_E);

        col_d         = col_q;
        row_d         = row_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        active_d      = active_q;
        vga_hs_d      = vga_hs_q;
        vga_vs_d      = vga_vs_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;

        // Pulses drop to 0 when frozen so they never stretch across a stall.
        if (i_enable) begin
            col_d         = col_nx;
            row_d         = row_nx;
            hsync_d       = ({1'b0, col_nx} < H_ACT);
            vsync_d       = ({1'b0, row_nx} < V_ACT);
            active_d      = ({1'b0, col_nx} < H_ACT) && ({1'b0, row_nx} < V_ACT);
            vga_hs_d      = h_pulse ^ PIN_IDLE;
            vga_vs_d      = v_pulse ^ PIN_IDLE;
            line_start_d  = (col_nx == '0);
            frame_start_d = (col_nx == '0) && (row_nx == '0);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            col_q         <= COL_LAST;
            row_q         <= ROW_LAST;
            hsync_q       <= 1'b0;
            vsync_q       <= 1'b0;
            active_q      <= 1'b0;
            vga_hs_q      <= PIN_IDLE;
            vga_vs_q      <= PIN_IDLE;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            col_q         <= col_d;
            row_q         <= row_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            active_q      <= active_d;
            vga_hs_q      <= vga_hs_d;
            vga_vs_q      <= vga_vs_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    // Simulation guard against timing parameters the counters cannot represent.
    always_ff @(posedge i_clk) begin
        assert (PARAMS_OK);
    end

    assign o_col_count   = col_q;
    assign o_row_count   = row_q;
    assign o_hsync       = hsync_q;
    assign o_vsync       = vsync_q;
    assign o_active      = active_q;
    assign o_vga_hs      = vga_hs_q;
    assign o_vga_vs      = vga_vs_q;
    assign o_line_start  = line_start_q;
    assign o_frame_start = frame_start_q;

endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

Timing generator that produces the horizontal/vertical sync, blanking and pixel-position signals for the VGA pong path from the 25 MHz pixel clock. It drives the internal active-area sync convention consumed by the downstream row/column tracking logic: a rising edge on `o_vsync` marks pixel (0,0). It also drives the porch-adjusted, polarity-configurable sync pins for the DAC/connector.

## Interface
- `TOTAL_COLS`, 800: pixel clocks per line.
- `TOTAL_ROWS`, 525: lines per frame.
- `ACTIVE_COLS`, 640: visible pixels per line.
- `ACTIVE_ROWS`, 480: visible lines per frame.
- `H_FRONT_PORCH`, 16: pixels from end of active to start of horizontal sync pulse.
- `H_SYNC_WIDTH`, 96: horizontal sync pulse width in pixels.
- `V_FRONT_PORCH`, 10: lines from end of active to start of vertical sync pulse.
- `V_SYNC_WIDTH`, 2: vertical sync pulse width in lines.
- `SYNC_ACTIVE_LOW`, 1: 1 means pin syncs are low during the pulse; 0 means high.

- `i_clk`  in  1  25 MHz pixel clock.
- `i_rst_n`  in  1  reset, asynchronous assert, active-low.
- `i_enable`  in  1  advance one pixel per clock when high; freeze when low.
- `o_hsync`  out  1  internal convention: high while `o_col_count` < ACTIVE_COLS.
- `o_vsync`  out  1  internal convention: high while `o_row_count` < ACTIVE_ROWS.
- `o_vga_hs`  out  1  pin horizontal sync, porch-adjusted, polarity per SYNC_ACTIVE_LOW.
- `o_vga_vs`  out  1  pin vertical sync, porch-adjusted, polarity per SYNC_ACTIVE_LOW.
- `o_active`  out  1  `o_hsync` AND `o_vsync`.
- `o_col_count`  out  10  current column, 0..TOTAL_COLS-1.
- `o_row_count`  out  10  current row, 0..TOTAL_ROWS-1.
- `o_line_start`  out  1  one-cycle pulse when `o_col_count` becomes 0.
- `o_frame_start`  out  1  one-cycle pulse when (col,row) becomes (0,0).

## Operation
- Column counter increments on each enabled clock and wraps TOTAL_COLS-1 → 0.
- On a column wrap, the row counter increments and wraps TOTAL_ROWS-1 → 0.
- Horizontal pulse region: ACTIVE_COLS+H_FRONT_PORCH ≤ col < ACTIVE_COLS+H_FRONT_PORCH+H_SYNC_WIDTH.
- Vertical pulse region: same form using the row counter and V_ parameters.
- `o_vga_hs` equals (in pulse region) XOR SYNC_ACTIVE_LOW; `o_vga_vs` likewise.
- Porches and pulse widths apply to pins only. `o_hsync`/`o_vsync` are pure active-area flags.
- Legal parameters: ACTIVE+FRONT_PORCH+SYNC_WIDTH ≤ TOTAL on each axis; TOTAL ≤ 1024. Other values are unsupported. Guard them with a simulation-only check.
- `i_enable` low: counters and every output hold their values. `o_line_start`/`o_frame_start` are forced to 0, so a pulse is never stretched or repeated. Counting resumes from the held position.

## Timing
- All outputs are registered and decoded from the next-state counter value. Every flag is therefore coherent with `o_col_count`/`o_row_count` in the same cycle, with no skew between outputs.
- Reset state (asynchronous, while `i_rst_n` = 0):
  - `o_col_count` = TOTAL_COLS-1, `o_row_count` = TOTAL_ROWS-1.
  - `o_hsync` = `o_vsync` = `o_active` = 0; line/frame pulses = 0.
  - Pin syncs at the inactive level (1 when SYNC_ACTIVE_LOW = 1).
- First enabled clock after reset release:
  - Counters go to (0,0).
  - `o_hsync`, `o_vsync`, `o_active`, `o_line_start`, `o_frame_start` all go 1 together.
  - This gives a clean `o_vsync` rising edge for downstream alignment.
- Reset mid-frame returns to the reset state immediately. No partial pulse completes.
- Horizontal pin pulse is exactly H_SYNC_WIDTH enabled clocks. Vertical pin pulse is exactly V_SYNC_WIDTH×TOTAL_COLS enabled clocks and starts on a column-0 boundary.
- Frame period is TOTAL_COLS×TOTAL_ROWS enabled clocks (420000 at defaults).

## Test plan
- Reset and release with `i_enable`=1 → outputs (799,524) during reset with all flags 0 and pins 1. First clock gives (0,0) with `o_frame_start`=`o_line_start`=`o_active`=1. Second clock gives col=1 with both pulses 0.
- Run one line → `o_hsync` high for exactly 640 clocks. `o_vga_hs` low from col 656 through 751 (96 clocks). `o_line_start` pulses at each col 0. `o_active`=0 for cols 640..799.
- Run one full frame → `o_vsync` falls at row 480. `o_vga_vs` is low for rows 490..491 (1600 clocks). `o_frame_start` pulses exactly once in 420000 clocks, at (0,0).
- Deassert `i_enable` for 5 clocks at col 0 → counters hold at (0,r). `o_line_start` asserts only in its original cycle. After re-enable, col=1 follows, and total line length is still 800 enabled clocks.
- Assert `i_rst_n`=0 asynchronously at (700,300) between clock edges → outputs reach the reset values before the next edge. After release, the frame restarts at (0,0).
- Small config: 10/6/4/3/1/2/1/1 with SYNC_ACTIVE_LOW=0 → `o_vga_hs` high at cols 5..6 only. `o_vga_vs` high for row 4 only. Frame length is 60 clocks.
